sum_accumulator: RTL and testbench

- Downstream stage of the 4-bit adder: consumes its 5-bit sum through a valid/ready handshake.
- Accumulates a frame of N_SAMPLES sums into a wider total, then presents the total and sample count on a valid/ready output.
- A flush input closes a partial frame early.
- Feeds the result-reporting logic; checked by a bound assertion module.

---
 rtl/adder_pkg.sv | 17 +
 rtl/sum_accumulator_if.sv | 30 +++
 rtl/sum_accumulator_assert.sv | 32 +++
 rtl/sum_accumulator.sv | 82 ++++++++
 tb/tb_sum_accumulator.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder result path: sum width, accumulator
// FSM states and the accumulator width rule.
package adder_pkg;

    localparam int SUM_W = 5;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Wide enough that n maximum-valued sums can never wrap.
    function automatic int acc_width(input int n);
        return SUM_W + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder, the sum accumulator and the
// result consumer.
interface sum_accumulator_if #(
    parameter int N_SAMPLES = 4
);
    import adder_pkg::*;

    localparam int ACC_W = acc_width(N_SAMPLES);
    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_sum, flush, out_ready,
        input  in_ready, out_valid, out_total, out_count
    );

    modport slave (
        input  in_valid, in_sum, flush, out_ready,
        output in_ready, out_valid, out_total, out_count
    );

endinterface

// File: rtl/sum_accumulator_assert.sv
// Protocol checker for the accumulator's output handshake; attached to
// sum_accumulator with bind.
module sum_accumulator_assert
    import adder_pkg::*;
#(
    parameter  int N_SAMPLES = 4,
    localparam int ACC_W     = acc_width(N_SAMPLES),
    localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input logic             clk,
    input logic             rst,
    input logic             out_valid,
    input logic             out_ready,
    input logic [ACC_W-1:0] out_total,
    input logic [CNT_W-1:0] out_count
);

    localparam int MAX_SUM = (2 ** SUM_W) - 1;

    valid_held: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid);

    data_stable: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> $stable(out_total) && $stable(out_count));

    count_nonzero: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> out_count != '0);

    total_bounded: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> int'(out_total) <= int'(out_count) * MAX_SUM);

endmodule

// File: rtl/sum_accumulator.sv
// Frames incoming adder sums into totals of up to N_SAMPLES samples and
// presents each total with its sample count on a valid/ready output.
module sum_accumulator
    import adder_pkg::*;
#(
    parameter  int N_SAMPLES = 4,
    localparam int ACC_W     = acc_width(N_SAMPLES),
    localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input logic              clk,
    input logic              rst,
    sum_accumulator_if.slave bus
);

    if (N_SAMPLES < 2 || N_SAMPLES > 16) begin : g_bad_param
        $error("sum_accumulator: N_SAMPLES must be in 2..16");
    end

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] total;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             ready;
    logic             downstream_ready;
    logic             accept;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;

    assign ready            = !rst && (state == ACCUM);
    assign valid            = (state == HOLD);
    assign downstream_ready = bus.out_ready;
    assign accept           = bus.in_valid && ready;
    assign acc_next         = acc + ACC_W'(bus.in_sum);
    assign cnt_next         = cnt + CNT_W'(1);

    // A flush riding on an accepted sample closes the frame including that
    // sample, so the frame-completing case and the flush case share a path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            total <= '0;
            count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == CNT_W'(N_SAMPLES - 1) || bus.flush) begin
                            state <= HOLD;
                            total <= acc_next;
                            count <= cnt_next;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt_next;
                        end
                    end else if (bus.flush && cnt != '0) begin
                        state <= HOLD;
                        total <= acc;
                        count <= cnt;
                    end
                end
                HOLD: begin
                    if (downstream_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_total = total;
    assign bus.out_count = count;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: frames, backpressure, flush,
// mid-frame reset and gapped input with hand-computed totals.
module tb_sum_accumulator;
    import adder_pkg::*;

    localparam int N_SAMPLES = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    sum_accumulator_if #(.N_SAMPLES(N_SAMPLES)) bus ();

    sum_accumulator #(.N_SAMPLES(N_SAMPLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    bind sum_accumulator sum_accumulator_assert #(.N_SAMPLES(N_SAMPLES)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .out_valid (valid),
        .out_ready (downstream_ready),
        .out_total (total),
        .out_count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v, input bit fl = 1'b0);
        bus.in_valid = 1'b1;
        bus.in_sum   = SUM_W'(v);
        bus.flush    = fl;
        cycle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic idle(input int cycles);
        bus.in_valid = 1'b0;
        bus.in_sum   = SUM_W'(31);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    // Expects a frame to be presented now; out_ready is high, so it drains
    // on the next edge.
    task automatic frame_check(input string tag, input int exp_total, input int exp_count);
        check({tag, "_valid"}, int'(bus.out_valid), 1);
        check({tag, "_total"}, int'(bus.out_total), exp_total);
        check({tag, "_count"}, int'(bus.out_count), exp_count);
        check({tag, "_in_ready_hold"}, int'(bus.in_ready), 0);
        cycle();
        check({tag, "_drained"}, int'(bus.out_valid), 0);
        check({tag, "_in_ready_back"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        cycle();
        cycle();
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_total", int'(bus.out_total), 0);
        check("rst_out_count", int'(bus.out_count), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(bus.in_ready), 1);

        // Full frame, back-to-back, exactly one cycle of latency
        feed(3);
        feed(5);
        feed(7);
        check("full_not_early", int'(bus.out_valid), 0);
        feed(30);
        frame_check("full", 45, 4);

        feed(31); feed(31); feed(31); feed(31);
        frame_check("max", 124, 4);
        feed(0); feed(0); feed(0); feed(0);
        frame_check("zero", 0, 4);

        // Backpressure: output held stable, input refused
        bus.out_ready = 1'b0;
        feed(1); feed(2); feed(3); feed(4);
        bus.in_valid = 1'b1;
        bus.in_sum   = SUM_W'(17);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(bus.out_valid), 1);
            check("bp_total", int'(bus.out_total), 10);
            check("bp_count", int'(bus.out_count), 4);
            check("bp_in_ready", int'(bus.in_ready), 0);
            cycle();
        end
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        check("bp_drained", int'(bus.out_valid), 0);
        check("bp_in_ready_back", int'(bus.in_ready), 1);
        feed(2); feed(2); feed(2); feed(2);
        frame_check("bp_next", 8, 4);

        // Flush cases
        feed(10);
        feed(20);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        frame_check("flush_partial", 30, 2);

        bus.flush = 1'b1;
        cycle();
        check("flush_empty_a", int'(bus.out_valid), 0);
        cycle();
        check("flush_empty_b", int'(bus.out_valid), 0);
        bus.flush = 1'b0;

        feed(10);
        feed(6, 1'b1);
        frame_check("flush_with_accept", 16, 2);

        feed(1); feed(1); feed(1);
        feed(1, 1'b1);
        frame_check("flush_on_last", 4, 4);
        cycle();
        check("flush_on_last_single", int'(bus.out_valid), 0);

        // Reset mid-frame discards the partial frame
        feed(9);
        feed(9);
        rst = 1'b1;
        cycle();
        check("midrst_in_ready", int'(bus.in_ready), 0);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_total", int'(bus.out_total), 0);
        check("midrst_out_count", int'(bus.out_count), 0);
        rst = 1'b0;
        #1;
        feed(1); feed(2);
        check("midrst_no_early", int'(bus.out_valid), 0);
        feed(3); feed(4);
        frame_check("midrst", 10, 4);

        // Gapped input with garbage on in_sum during the gaps
        feed(6);
        idle(2);
        feed(7);
        idle(1);
        feed(8);
        check("gap_not_early", int'(bus.out_valid), 0);
        feed(9);
        frame_check("gapped", 30, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
